// File: rtl/mux_scan_sampler_if.sv
// Bus between the scan sequencer, the 4:1 select mux and the TDC frame capture.
// Optional macro MUX_SCAN_DEGLITCH_EN adds the glitch_seen frame flag.
interface mux_scan_sampler_if;
    logic       start;
    logic       busy;
    logic       sel_x;
    logic       sel_y;
    logic       mux_z;
    logic [3:0] frame_data;
    logic       frame_valid;
    logic       frame_ready;
    logic [7:0] frame_count;
`ifdef MUX_SCAN_DEGLITCH_EN
    logic       glitch_seen;
`endif

    // Sequencer side
    modport master (
        input  start, mux_z, frame_ready,
        output busy, sel_x, sel_y, frame_data, frame_valid, frame_count
`ifdef MUX_SCAN_DEGLITCH_EN
        , output glitch_seen
`endif
    );

    // Mux / capture side
    modport slave (
        output start, mux_z, frame_ready,
        input  busy, sel_x, sel_y, frame_data, frame_valid, frame_count
`ifdef MUX_SCAN_DEGLITCH_EN
        , input glitch_seen
`endif
    );
endinterface

// File: rtl/mux_scan_sampler.sv
// Mux scan sequencer: steps the 4:1 mux select over enabled channels, waits a
// settle interval, samples z and hands the 4-bit frame downstream (valid/ready).
// Optional macro MUX_SCAN_DEGLITCH_EN: 3-sample majority per channel + glitch_seen.
module mux_scan_sampler #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [3:0]  CH_MASK       = 4'b1111
) (
    input  logic               clk,
    input  logic               rst,
    mux_scan_sampler_if.master bus
);
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_t;

    state_t             r_state, w_state_nxt, w_after_sel;
    logic [1:0]         r_ch, w_ch_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [3:0]         r_data, w_data_nxt;
    logic               r_valid, w_valid_nxt;
    logic [7:0]         r_count, w_count_nxt;
    logic [2:0]         w_first, w_next;
    logic               w_last_smp, w_bit;
`ifdef MUX_SCAN_DEGLITCH_EN
    logic [1:0]         r_rep, w_rep_nxt;
    logic [1:0]         r_smp, w_smp_nxt;
    logic               r_glitch, w_glitch_nxt;
    logic               w_disagree;
`endif

    // Lowest enabled channel at or above 'from'; bit 2 flags that one exists
    function automatic logic [2:0] f_find(input logic [2:0] from);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (CH_MASK[i] && (3'(i) >= from)) res = {1'b1, 2'(i)};
        end
        return res;
    endfunction

    assign w_first     = f_find(3'd0);
    assign w_next      = f_find({1'b0, r_ch} + 3'd1);
    assign w_after_sel = (SETTLE_CYCLES == 0) ? ST_SAMPLE : ST_SETTLE;

`ifdef MUX_SCAN_DEGLITCH_EN
    assign w_last_smp = (r_rep == 2'd2);
    assign w_bit      = (r_smp[0] & r_smp[1]) | (r_smp[0] & bus.mux_z) | (r_smp[1] & bus.mux_z);
    assign w_disagree = !((r_smp[0] == r_smp[1]) && (r_smp[1] == bus.mux_z));
`else
    assign w_last_smp = 1'b1;
    assign w_bit      = bus.mux_z;
`endif

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ch     <= 2'd0;
            r_cnt    <= '0;
            r_data   <= 4'd0;
            r_valid  <= 1'b0;
            r_count  <= 8'd0;
`ifdef MUX_SCAN_DEGLITCH_EN
            r_rep    <= 2'd0;
            r_smp    <= 2'd0;
            r_glitch <= 1'b0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_ch     <= w_ch_nxt;
            r_cnt    <= w_cnt_nxt;
            r_data   <= w_data_nxt;
            r_valid  <= w_valid_nxt;
            r_count  <= w_count_nxt;
`ifdef MUX_SCAN_DEGLITCH_EN
            r_rep    <= w_rep_nxt;
            r_smp    <= w_smp_nxt;
            r_glitch <= w_glitch_nxt;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (bus.start) w_state_nxt = (CH_MASK == 4'd0) ? ST_DONE : w_after_sel;
            ST_SETTLE: if (r_cnt == CNT_W'(SETTLE_CYCLES - 1)) w_state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (w_last_smp) w_state_nxt = w_next[2] ? w_after_sel : ST_DONE;
            ST_DONE:   if (r_valid && bus.frame_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath next values: select, settle counter, capture, handshake
    always_comb begin
        w_ch_nxt     = r_ch;
        w_cnt_nxt    = r_cnt;
        w_data_nxt   = r_data;
        w_valid_nxt  = r_valid;
        w_count_nxt  = r_count;
`ifdef MUX_SCAN_DEGLITCH_EN
        w_rep_nxt    = r_rep;
        w_smp_nxt    = r_smp;
        w_glitch_nxt = r_glitch;
`endif
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_ch_nxt     = w_first[1:0];
                    w_cnt_nxt    = '0;
                    w_data_nxt   = 4'd0;
`ifdef MUX_SCAN_DEGLITCH_EN
                    w_rep_nxt    = 2'd0;
                    w_glitch_nxt = 1'b0;
`endif
                end
            end
            ST_SETTLE: w_cnt_nxt = r_cnt + CNT_W'(1);
            ST_SAMPLE: begin
                if (w_last_smp) begin
                    w_data_nxt[r_ch] = w_bit;
`ifdef MUX_SCAN_DEGLITCH_EN
                    w_rep_nxt        = 2'd0;
                    w_glitch_nxt     = r_glitch | w_disagree;
`endif
                    if (w_next[2]) begin
                        w_ch_nxt  = w_next[1:0];
                        w_cnt_nxt = '0;
                    end else begin
                        w_valid_nxt = 1'b1;
                    end
                end else begin
`ifdef MUX_SCAN_DEGLITCH_EN
                    w_smp_nxt[r_rep[0]] = bus.mux_z;
                    w_rep_nxt           = r_rep + 2'd1;
`endif
                end
            end
            ST_DONE: begin
                // Empty-mask scans enter DONE straight from IDLE; valid follows one cycle later
                if (!r_valid) begin
                    w_valid_nxt = 1'b1;
                end else if (bus.frame_ready) begin
                    w_valid_nxt = 1'b0;
                    w_count_nxt = r_count + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.busy        = (r_state != ST_IDLE);
    assign bus.sel_x       = r_ch[1];
    assign bus.sel_y       = r_ch[0];
    assign bus.frame_data  = r_data;
    assign bus.frame_valid = r_valid;
    assign bus.frame_count = r_count;
`ifdef MUX_SCAN_DEGLITCH_EN
    assign bus.glitch_seen = r_glitch;
`endif
endmodule
